// File: rtl/writeback_pkg.sv
// Shared definitions for the writeback stage: bus widths, zero constants and ALU op codes.
// Load op codes are grouped so the stage can tell a memory load from an ALU result.
package writeback_pkg;

  localparam int REG_W  = 32;
  localparam int HILO_W = 64;
  localparam int ADDR_W = 5;
  localparam int WEN_W  = 4;
  localparam int OP_W   = 8;
  localparam int CNT_W  = 64;

  localparam logic [REG_W-1:0]  ZERO_WORD  = 32'h0000_0000;
  localparam logic [HILO_W-1:0] ZERO_DWORD = 64'h0000_0000_0000_0000;

  localparam logic [OP_W-1:0] ALU_NOP = 8'h00;
  localparam logic [OP_W-1:0] ALU_LB  = 8'h20;
  localparam logic [OP_W-1:0] ALU_LH  = 8'h21;
  localparam logic [OP_W-1:0] ALU_LWL = 8'h22;
  localparam logic [OP_W-1:0] ALU_LW  = 8'h23;
  localparam logic [OP_W-1:0] ALU_LBU = 8'h24;
  localparam logic [OP_W-1:0] ALU_LHU = 8'h25;
  localparam logic [OP_W-1:0] ALU_LWR = 8'h26;
  localparam logic [OP_W-1:0] ALU_SC  = 8'h38;

  function automatic logic is_load(input logic [OP_W-1:0] op);
    logic r;
    case (op)
      ALU_LB, ALU_LBU, ALU_LH, ALU_LHU,
      ALU_LW, ALU_LWL, ALU_LWR: r = 1'b1;
      default:                  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/writeback_load_align.sv
// Combinational load alignment: extracts/extends the loaded bytes and produces the
// GPR byte-lane mask (partial for the unaligned LWL/LWR merges).
module load_align
  import writeback_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  input  logic [1:0]       off,
  input  logic [REG_W-1:0] rdata,
  output logic [REG_W-1:0] data,
  output logic [WEN_W-1:0] mask
);

  logic [REG_W-1:0] shifted;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;

  assign shifted = rdata >> {off, 3'b000};
  assign byte_v  = shifted[7:0];
  assign half_v  = off[1] ? rdata[31:16] : rdata[15:0];

  // Select the aligned load value and the lanes it may write
  always_comb begin
    data = ZERO_WORD;
    mask = 4'b1111;
    case (op)
      ALU_LB:  data = {{24{byte_v[7]}}, byte_v};
      ALU_LBU: data = {24'h00_0000, byte_v};
      ALU_LH:  data = {{16{half_v[15]}}, half_v};
      ALU_LHU: data = {16'h0000, half_v};
      ALU_LW:  data = rdata;
      ALU_LWL: begin
        data = rdata << {2'd3 - off, 3'b000};
        mask = 4'b1111 << (2'd3 - off);
      end
      ALU_LWR: begin
        data = shifted;
        mask = 4'b1111 >> off;
      end
      default: data = ZERO_WORD;
    endcase
  end

endmodule

// File: rtl/writeback.sv
// Writeback stage: zero-latency GPR write port plus HI/LO, LLbit, retire counter and
// last retired PC, with same-cycle bypass of HI/LO and LLbit writes.
module writeback
  import writeback_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  wb_pc,
  input  logic [OP_W-1:0]   wb_aluop,
  input  logic [REG_W-1:0]  wb_alures,
  input  logic [REG_W-1:0]  wb_m_vaddr,
  input  logic [REG_W-1:0]  wb_m_rdata,
  input  logic [WEN_W-1:0]  wb_wreg,
  input  logic [ADDR_W-1:0] wb_wraddr,
  input  logic              wb_hilo_wen,
  input  logic [HILO_W-1:0] wb_hilo,
  input  logic              wb_llb_wen,
  input  logic              wb_llbit,
  input  logic              llb_clr,
  output logic [WEN_W-1:0]  rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [REG_W-1:0]  rf_wdata,
  output logic [REG_W-1:0]  hi,
  output logic [REG_W-1:0]  lo,
  output logic              llbit,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [REG_W-1:0]  last_pc
);

  logic [REG_W-1:0] hi_r;
  logic [REG_W-1:0] lo_r;
  logic             llbit_r;
  logic [CNT_W-1:0] retire_cnt_r;
  logic [REG_W-1:0] last_pc_r;
  logic [REG_W-1:0] la_data;
  logic [WEN_W-1:0] la_mask;
  logic             retire;
  logic             unused_vaddr;

  assign unused_vaddr = ^wb_m_vaddr[REG_W-1:2];
  assign retire       = (wb_aluop != ALU_NOP);

  load_align u_load_align (
    .op    (wb_aluop),
    .off   (wb_m_vaddr[1:0]),
    .rdata (wb_m_rdata),
    .data  (la_data),
    .mask  (la_mask)
  );

  assign rf_waddr = wb_wraddr;
  assign rf_wen   = wb_wreg & la_mask;

  // Loads write the aligned memory word; everything else (including SC) the ALU result
  always_comb begin
    if (is_load(wb_aluop)) begin
      rf_wdata = la_data;
    end else begin
      rf_wdata = wb_alures;
    end
  end

  // Architectural state outputs read as reset values while rst is held
  always_comb begin
    if (rst) begin
      hi    = ZERO_WORD;
      lo    = ZERO_WORD;
      llbit = 1'b0;
    end else begin
      if (wb_hilo_wen) begin
        hi = wb_hilo[63:32];
        lo = wb_hilo[31:0];
      end else begin
        hi = hi_r;
        lo = lo_r;
      end
      if (llb_clr) begin
        llbit = 1'b0;
      end else if (wb_llb_wen) begin
        llbit = wb_llbit;
      end else begin
        llbit = llbit_r;
      end
    end
  end

  assign retire_cnt = retire_cnt_r;
  assign last_pc    = last_pc_r;

  // HI/LO, LLbit, retire counter and last PC state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r         <= ZERO_WORD;
      lo_r         <= ZERO_WORD;
      llbit_r      <= 1'b0;
      retire_cnt_r <= ZERO_DWORD;
      last_pc_r    <= ZERO_WORD;
    end else begin
      if (wb_hilo_wen) begin
        hi_r <= wb_hilo[63:32];
        lo_r <= wb_hilo[31:0];
      end
      if (llb_clr) begin
        llbit_r <= 1'b0;
      end else if (wb_llb_wen) begin
        llbit_r <= wb_llbit;
      end
      if (retire) begin
        retire_cnt_r <= retire_cnt_r + 64'd1;
        last_pc_r    <= wb_pc;
      end
    end
  end

endmodule

// File: tb/tb_writeback.sv
// Randomized bench for writeback: a behavioural model tracks architectural state and
// every cycle's outputs are compared against it, plus hand-computed pinning checks.
module tb_writeback;
  import writeback_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_pc;
  logic [7:0]  wb_aluop;
  logic [31:0] wb_alures;
  logic [31:0] wb_m_vaddr;
  logic [31:0] wb_m_rdata;
  logic [3:0]  wb_wreg;
  logic [4:0]  wb_wraddr;
  logic        wb_hilo_wen;
  logic [63:0] wb_hilo;
  logic        wb_llb_wen;
  logic        wb_llbit;
  logic        llb_clr;
  logic [3:0]  rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        llbit;
  logic [63:0] retire_cnt;
  logic [31:0] last_pc;

  // behavioural model of architectural state
  logic [31:0] m_hi, m_lo, m_pc;
  logic        m_ll;
  logic [63:0] m_cnt;

  int total = 0;
  int bad   = 0;

  logic [7:0] op_tab [12];

  always #5 clk = ~clk;

  writeback dut (
    .clk(clk), .rst(rst), .wb_pc(wb_pc), .wb_aluop(wb_aluop), .wb_alures(wb_alures),
    .wb_m_vaddr(wb_m_vaddr), .wb_m_rdata(wb_m_rdata), .wb_wreg(wb_wreg),
    .wb_wraddr(wb_wraddr), .wb_hilo_wen(wb_hilo_wen), .wb_hilo(wb_hilo),
    .wb_llb_wen(wb_llb_wen), .wb_llbit(wb_llbit), .llb_clr(llb_clr),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .hi(hi), .lo(lo),
    .llbit(llbit), .retire_cnt(retire_cnt), .last_pc(last_pc)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_wdata(input logic [7:0] op, input logic [1:0] off,
                                            input logic [31:0] rd, input logic [31:0] alu);
    int o;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    o = int'(off);
    b = rd[8*o +: 8];
    h = rd[16*(o/2) +: 16];
    case (op)
      ALU_LB:  r = 32'(int'($signed(b)));
      ALU_LBU: r = 32'(int'(b));
      ALU_LH:  r = 32'(int'($signed(h)));
      ALU_LHU: r = 32'(int'(h));
      ALU_LW:  r = rd;
      ALU_LWL: r = rd << (8 * (3 - o));
      ALU_LWR: r = rd >> (8 * o);
      default: r = alu;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] exp_mask(input logic [7:0] op, input logic [1:0] off);
    logic [3:0] r;
    if (op == ALU_LWL) begin
      case (off)
        2'd0: r = 4'b1000;
        2'd1: r = 4'b1100;
        2'd2: r = 4'b1110;
        default: r = 4'b1111;
      endcase
    end else if (op == ALU_LWR) begin
      case (off)
        2'd0: r = 4'b1111;
        2'd1: r = 4'b0111;
        2'd2: r = 4'b0011;
        default: r = 4'b0001;
      endcase
    end else begin
      r = 4'b1111;
    end
    return r;
  endfunction

  task automatic compare_all();
    logic [31:0] e_hi, e_lo;
    logic        e_ll;
    e_hi = rst ? 32'h0 : (wb_hilo_wen ? wb_hilo[63:32] : m_hi);
    e_lo = rst ? 32'h0 : (wb_hilo_wen ? wb_hilo[31:0] : m_lo);
    e_ll = rst ? 1'b0 : (llb_clr ? 1'b0 : (wb_llb_wen ? wb_llbit : m_ll));
    check("rf_waddr", 64'(rf_waddr), 64'(wb_wraddr));
    check("rf_wen", 64'(rf_wen), 64'(wb_wreg & exp_mask(wb_aluop, wb_m_vaddr[1:0])));
    check("rf_wdata", 64'(rf_wdata),
          64'(exp_wdata(wb_aluop, wb_m_vaddr[1:0], wb_m_rdata, wb_alures)));
    check("hi", 64'(hi), 64'(e_hi));
    check("lo", 64'(lo), 64'(e_lo));
    check("llbit", 64'(llbit), 64'(e_ll));
    check("retire_cnt", retire_cnt, m_cnt);
    check("last_pc", 64'(last_pc), 64'(m_pc));
  endtask

  task automatic model_reset();
    m_hi = 32'h0; m_lo = 32'h0; m_ll = 1'b0; m_cnt = 64'h0; m_pc = 32'h0;
  endtask

  // one clock: compare at the falling edge, then advance the model across the rising edge
  task automatic cycle();
    logic [31:0] n_hi, n_lo, n_pc;
    logic        n_ll;
    logic [63:0] n_cnt;
    @(negedge clk);
    compare_all();
    n_hi = m_hi; n_lo = m_lo; n_ll = m_ll; n_cnt = m_cnt; n_pc = m_pc;
    if (wb_hilo_wen) begin n_hi = wb_hilo[63:32]; n_lo = wb_hilo[31:0]; end
    if (llb_clr) n_ll = 1'b0;
    else if (wb_llb_wen) n_ll = wb_llbit;
    if (wb_aluop != ALU_NOP) begin n_cnt = m_cnt + 64'd1; n_pc = wb_pc; end
    @(posedge clk);
    if (rst) model_reset();
    else begin m_hi = n_hi; m_lo = n_lo; m_ll = n_ll; m_cnt = n_cnt; m_pc = n_pc; end
    #1;
  endtask

  task automatic idle_inputs();
    wb_pc = 32'h0; wb_aluop = ALU_NOP; wb_alures = 32'h0; wb_m_vaddr = 32'h0;
    wb_m_rdata = 32'h0; wb_wreg = 4'h0; wb_wraddr = 5'd0; wb_hilo_wen = 1'b0;
    wb_hilo = 64'h0; wb_llb_wen = 1'b0; wb_llbit = 1'b0; llb_clr = 1'b0;
  endtask

  task automatic random_inputs();
    wb_pc       = $urandom & 32'hFFFF_FFFC;
    wb_aluop    = op_tab[$urandom_range(0, 11)];
    wb_alures   = $urandom;
    wb_m_vaddr  = $urandom;
    wb_m_rdata  = $urandom;
    wb_wreg     = (wb_aluop == ALU_NOP) ? 4'h0 : 4'($urandom);
    wb_wraddr   = 5'($urandom);
    wb_hilo_wen = ($urandom_range(0, 2) == 0);
    wb_hilo     = {32'($urandom), 32'($urandom)};
    wb_llb_wen  = ($urandom_range(0, 2) == 0);
    wb_llbit    = 1'($urandom);
    llb_clr     = ($urandom_range(0, 5) == 0);
  endtask

  initial begin
    op_tab = '{ALU_NOP, ALU_LB, ALU_LBU, ALU_LH, ALU_LHU, ALU_LW, ALU_LWL, ALU_LWR,
               ALU_SC, 8'h01, 8'h5A, ALU_NOP};
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #12;
    @(posedge clk); #1;
    check("reset_hi", 64'(hi), 64'h0);
    check("reset_cnt", retire_cnt, 64'h0);
    cycle();
    rst = 1'b0;
    cycle();

    // LB sign extension of byte 2
    wb_aluop = ALU_LB; wb_m_vaddr = 32'h0000_1002; wb_m_rdata = 32'h12F4_5678;
    wb_wreg = 4'b1111; wb_pc = 32'h0000_0100; #1;
    check("lb_data", 64'(rf_wdata), 64'hFFFF_FFF4);
    check("lb_wen", 64'(rf_wen), 64'hF);
    cycle();

    // LWL / LWR partial merges
    wb_aluop = ALU_LWL; wb_m_vaddr = 32'h0000_2001; wb_m_rdata = 32'hAABB_CCDD; #1;
    check("lwl_data", 64'(rf_wdata), 64'hCCDD_0000);
    check("lwl_wen", 64'(rf_wen), 64'hC);
    cycle();
    wb_aluop = ALU_LWR; wb_m_vaddr = 32'h0000_2002; #1;
    check("lwr_data", 64'(rf_wdata), 64'h0000_AABB);
    check("lwr_wen", 64'(rf_wen), 64'h3);
    cycle();

    // HI/LO bypass then hold
    idle_inputs();
    wb_hilo_wen = 1'b1; wb_hilo = 64'h0000_0001_0000_0002; #1;
    check("hilo_byp_hi", 64'(hi), 64'h1);
    check("hilo_byp_lo", 64'(lo), 64'h2);
    cycle();
    wb_hilo_wen = 1'b0; wb_hilo = 64'hDEAD_BEEF_CAFE_F00D; #1;
    check("hilo_hold_hi", 64'(hi), 64'h1);
    check("hilo_hold_lo", 64'(lo), 64'h2);
    cycle();

    // LLbit clear beats write, then write alone
    wb_llb_wen = 1'b1; wb_llbit = 1'b1; llb_clr = 1'b1; #1;
    check("ll_clr_win_now", 64'(llbit), 64'h0);
    cycle();
    llb_clr = 1'b0; wb_llb_wen = 1'b0; #1;
    check("ll_clr_win_after", 64'(llbit), 64'h0);
    wb_llb_wen = 1'b1; #1;
    check("ll_set", 64'(llbit), 64'h1);
    cycle();
    idle_inputs();

    // counter wrap from a preloaded all-ones value, then a bubble
    force dut.retire_cnt_r = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retire_cnt_r;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    check("cnt_preload", retire_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    wb_aluop = ALU_SC; wb_pc = 32'h0000_0ABC;
    cycle();
    check("cnt_wrap", retire_cnt, 64'h0);
    check("pc_load", 64'(last_pc), 64'h0ABC);
    wb_aluop = ALU_NOP; wb_pc = 32'h0000_0FFF;
    cycle();
    check("nop_cnt", retire_cnt, 64'h0);
    check("nop_pc", 64'(last_pc), 64'h0ABC);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      random_inputs();
      cycle();
    end

    // asynchronous reset mid-stream with a HI/LO write pending
    random_inputs();
    wb_hilo_wen = 1'b1; wb_llb_wen = 1'b1; wb_llbit = 1'b1; llb_clr = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("arst_hi", 64'(hi), 64'h0);
    check("arst_lo", 64'(lo), 64'h0);
    check("arst_ll", 64'(llbit), 64'h0);
    check("arst_cnt", retire_cnt, 64'h0);
    check("arst_pc", 64'(last_pc), 64'h0);
    cycle();
    random_inputs();
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      random_inputs();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1 (rising edge), rst input 1 (asynchronous, active-high).
REQ-002 wb_pc input 32: PC of the instruction in WB.
REQ-003 wb_aluop input 8: operation code; ALU_NOP marks a bubble.
REQ-004 wb_alures input 32: ALU result, also the SC result.
REQ-005 wb_m_vaddr input 32: load virtual address; only bits [1:0] are used.
REQ-006 wb_m_rdata input 32: raw word read from memory.
REQ-007 wb_wreg input 4: byte write enables requested for the destination GPR.
REQ-008 wb_wraddr input 5: destination GPR index.
REQ-009 wb_hilo_wen input 1, wb_hilo input 64 {HI,LO}: HI/LO write request.
REQ-010 wb_llb_wen input 1, wb_llbit input 1: LLbit write request.
REQ-011 llb_clr input 1: exception/ERET clear of LLbit.
REQ-012 rf_wen output 4, rf_waddr output 5, rf_wdata output 32: GPR write port.
REQ-013 hi output 32, lo output 32: architectural HI/LO, with same-cycle bypass.
REQ-014 llbit output 1: architectural LLbit, with same-cycle bypass.
REQ-015 retire_cnt output 64: count of retired non-bubble instructions.
REQ-016 last_pc output 32: PC of the most recently retired non-bubble instruction.

Function
REQ-017 GPR path SHALL be combinational, zero latency: rf_waddr = wb_wraddr, and rf_wen = wb_wreg AND lane mask.
REQ-018 Lane mask SHALL be 4'b1111 for every op except LWL and LWR.
REQ-019 Byte offset off = wb_m_vaddr[1:0], little-endian.
REQ-020 LB/LBU: rf_wdata = byte rdata[8*off+7:8*off], sign-extended for LB, zero-extended for LBU.
REQ-021 LH/LHU: rf_wdata = halfword rdata[16*off[1]+15:16*off[1]], sign-extended for LH, zero-extended for LHU; off[0] is ignored.
REQ-022 LW: rf_wdata = rdata.
REQ-023 LWL: rf_wdata = rdata << 8*(3-off); mask = off 0:1000, 1:1100, 2:1110, 3:1111.
REQ-024 LWR: rf_wdata = rdata >> 8*off; mask = off 0:1111, 1:0111, 2:0011, 3:0001.
REQ-025 All other ops: rf_wdata = wb_alures.
REQ-026 HI/LO registers SHALL load wb_hilo[63:32] and wb_hilo[31:0] on the clock edge where wb_hilo_wen=1, and hold otherwise.
REQ-027 hi/lo outputs SHALL equal wb_hilo while wb_hilo_wen=1, and the registers otherwise (bypass).
REQ-028 LLbit register SHALL clear on llb_clr=1; else load wb_llbit when wb_llb_wen=1; else hold.
REQ-029 When llb_clr and wb_llb_wen are both 1 in the same cycle, llb_clr SHALL win.
REQ-030 llbit output SHALL equal 0 while llb_clr=1, else wb_llbit while wb_llb_wen=1, else the register (bypass).
REQ-031 retire_cnt SHALL increment by 1 on each edge where wb_aluop != ALU_NOP, and SHALL wrap modulo 2^64.
REQ-032 last_pc SHALL load wb_pc on each edge where wb_aluop != ALU_NOP.
REQ-033 Bubbles (ALU_NOP with wb_wreg=0) SHALL cause no architectural state change.

Reset
REQ-034 On rst the registers SHALL reset to: hi=0, lo=0, LLbit=0, retire_cnt=0, last_pc=0.
REQ-035 rst asserted mid-operation SHALL override any same-cycle write; combinational outputs SHALL still follow their inputs during reset.

Structure
REQ-036 ALU op codes (ALU_NOP, LB, LBU, LH, LHU, LW, LWL, LWR, SC), the zero constants and the bus widths SHALL come from the shared defines package.
REQ-037 The load-alignment logic SHALL be one combinational sub-module, load_align, that maps op, off and rdata to data and mask.

Verification
REQ-038 LB, vaddr=..02, rdata=0x12F45678, wreg=1111 -> rf_wdata=0xFFFFFFF4, rf_wen=1111.
REQ-039 LWL off=1, rdata=0xAABBCCDD, wreg=1111 -> rf_wdata=0xCCDD0000, rf_wen=1100; LWR off=2 -> rf_wdata=0x0000AABB, rf_wen=0011.
REQ-040 hilo_wen=1, hilo=0x00000001_00000002 -> hi/lo read 1/2 in the same cycle, and the registers hold 1/2 after the edge and after wen drops.
REQ-041 llb_wen=1, llbit=1 together with llb_clr=1 -> llbit=0 before and after the edge; llb_wen alone -> llbit=1.
REQ-042 Preload retire_cnt=0xFFFFFFFF_FFFFFFFF with a non-NOP op -> retire_cnt=0 after the edge; an ALU_NOP op -> retire_cnt and last_pc unchanged.
REQ-043 rst asserted asynchronously mid-stream with hilo_wen=1 -> hi=lo=0, llbit=0, retire_cnt=0 immediately, with no clock edge needed.
